// File: rtl/grf_arb_pkg.sv
// Shared defaults and entry type for the GRF write arbiter.
package grf_arb_pkg;

    localparam int unsigned AW_DEF = 5;
    localparam int unsigned DW_DEF = 32;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } grf_entry_t;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Writeback / secondary-result / decode-query / GRF-write bundle for the arbiter.
interface grf_write_arbiter_if
    import grf_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_stall;
    logic          sec_valid;
    logic          sec_ready;
    logic [AW-1:0] sec_addr;
    logic [DW-1:0] sec_data;
    logic [AW-1:0] q_addr1;
    logic [AW-1:0] q_addr2;
    logic [AW-1:0] q_addr3;
    logic          hazard;
    logic          grf_we;
    logic [AW-1:0] grf_waddr;
    logic [DW-1:0] grf_wdata;

    modport slave (
        input  wb_valid, wb_addr, wb_data, sec_valid, sec_addr, sec_data,
               q_addr1, q_addr2, q_addr3,
        output wb_stall, sec_ready, hazard, grf_we, grf_waddr, grf_wdata
    );

    modport master (
        output wb_valid, wb_addr, wb_data, sec_valid, sec_addr, sec_data,
               q_addr1, q_addr2, q_addr3,
        input  wb_stall, sec_ready, hazard, grf_we, grf_waddr, grf_wdata
    );
endinterface

// File: rtl/grf_arb_fifo.sv
// DEPTH-entry circular buffer for deferred secondary GRF writes; exposes
// per-slot valid/address vectors so the top can check decode hazards.
module grf_arb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  logic [AW-1:0]       push_addr_i,
    input  logic [DW-1:0]       push_data_i,
    input  logic                pop_i,
    output logic [AW-1:0]       head_addr_o,
    output logic [DW-1:0]       head_data_o,
    output logic [CW-1:0]       count_o,
    output logic [DEPTH-1:0]    ent_valid_o,
    output logic [DEPTH*AW-1:0] ent_addr_o
);
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [DEPTH-1:0]   valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
        if (push_i) valid_d[wr_ptr_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{addr: push_addr_i, data: push_data_i};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        ent_addr_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_addr_o[i*AW +: AW] = mem_q[i].addr;
        end
    end

    assign head_addr_o = mem_q[rd_ptr_q].addr;
    assign head_data_o = mem_q[rd_ptr_q].data;
    assign count_o     = count_q;
    assign ent_valid_o = valid_q;
endmodule

// File: rtl/grf_write_arbiter.sv
// Shares the GRF write port between writeback (primary) and a buffered secondary
// producer. Optional starvation guard: define GRF_ARB_STARVE_GUARD_EN.
module grf_write_arbiter
    import grf_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    grf_write_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_cfg
        $error("grf_write_arbiter: DEPTH must be a power of 2 >= 2 and MAX_WAIT >= 1");
    end

    logic [AW-1:0]       head_addr;
    logic [DW-1:0]       head_data;
    logic [CW-1:0]       count;
    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH*AW-1:0] ent_addr;
    logic                push, pop, fifo_ne, wb_req, sec_ready_w, force_head;

    assign fifo_ne     = (count != '0);
    assign wb_req      = bus.wb_valid && (bus.wb_addr != '0);
    assign sec_ready_w = !reset && (count < CW'(DEPTH));
    // Address-0 results complete the handshake but are dropped: $0 is never written.
    assign push        = bus.sec_valid && sec_ready_w && (bus.sec_addr != '0);

    grf_arb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_addr_i (bus.sec_addr),
        .push_data_i (bus.sec_data),
        .pop_i       (pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (count),
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr)
    );

`ifdef GRF_ARB_STARVE_GUARD_EN
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_q;

    assign force_head = fifo_ne && (wait_q == WW'(MAX_WAIT));

    // Non-empty without a pop means the primary held the port this cycle.
    always_ff @(posedge clk) begin
        if (reset || !fifo_ne || pop) wait_q <= '0;
        else                          wait_q <= wait_q + WW'(1);
    end
`else
    assign force_head = 1'b0;
`endif

    assign bus.wb_stall  = !reset && force_head;
    assign bus.sec_ready = sec_ready_w;

    always_comb begin
        bus.grf_we    = 1'b0;
        bus.grf_waddr = '0;
        bus.grf_wdata = '0;
        pop           = 1'b0;
        if (!reset) begin
            if (wb_req && !force_head) begin
                bus.grf_we    = 1'b1;
                bus.grf_waddr = bus.wb_addr;
                bus.grf_wdata = bus.wb_data;
            end else if (fifo_ne) begin
                bus.grf_we    = 1'b1;
                bus.grf_waddr = head_addr;
                bus.grf_wdata = head_data;
                pop           = 1'b1;
            end
        end
    end

    logic [AW-1:0] qa [3];
    assign qa[0] = bus.q_addr1;
    assign qa[1] = bus.q_addr2;
    assign qa[2] = bus.q_addr3;

    always_comb begin
        bus.hazard = 1'b0;
        if (!reset) begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (qa[k] != '0) begin
                    if (bus.sec_valid && bus.sec_addr == qa[k]) bus.hazard = 1'b1;
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (ent_valid[i] && ent_addr[i*AW +: AW] == qa[k]) bus.hazard = 1'b1;
                    end
                end
            end
        end
    end
endmodule
